// File: rtl/damage_gate_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : damage_gate_pkg
//  Description : Shared game package: gate state encoding, hit tally width
//                and default timing constants for timed game blocks.
//  Revision    : 1.0  initial release
// ============================================================================
package damage_gate_pkg;

  // Damage gate states, 2-bit encoding
  typedef enum logic [1:0] {
    ST_ARMED    = 2'd0,
    ST_STRIKE   = 2'd1,
    ST_COOLDOWN = 2'd2,
    ST_HALT     = 2'd3
  } gate_state_t;

  // Width of the saturating hit tally
  localparam int HIT_TOTAL_W = 8;

  // Default timing: 25 ms ticks at 100 MHz, 40-tick invulnerability
  localparam int DEF_TICK_DIV       = 2500000;
  localparam int DEF_COOLDOWN_TICKS = 40;

endpackage : damage_gate_pkg
`default_nettype wire

// File: rtl/damage_gate_if.sv
`default_nettype none
// ============================================================================
//  Module      : damage_gate_if
//  Description : Game-side bundle for the damage gate: collision levels,
//                run/dead status in; damage pulse, i-frame flags, tally out.
//  Revision    : 1.0  initial release
// ============================================================================
interface damage_gate_if
  import damage_gate_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int SRC_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) ();

  logic                   enable;
  logic                   dead;
  logic [NUM_SRC-1:0]     hit;
  logic                   damage;
  logic                   invuln;
  logic                   blink;
  logic [SRC_W-1:0]       hit_src;
  logic [HIT_TOTAL_W-1:0] hit_total;

  // Game logic side: drives collisions and status, observes damage
  modport master (
    output enable, dead, hit,
    input  damage, invuln, blink, hit_src, hit_total
  );

  // Damage gate side
  modport slave (
    input  enable, dead, hit,
    output damage, invuln, blink, hit_src, hit_total
  );

endinterface : damage_gate_if
`default_nettype wire

// File: rtl/damage_gate_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tick_gen
//  Description : Enable-gated clock divider producing a one-cycle tick every
//                TICK_DIV enabled cycles; clr restarts the count.
//  Revision    : 1.0  initial release
// ============================================================================
module tick_gen
  import damage_gate_pkg::*;
#(
  parameter int TICK_DIV = DEF_TICK_DIV
) (
  input  wire  clk,
  input  wire  rst,
  input  wire  en,
  input  wire  clr,
  output logic tick
);

  localparam int              c_CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [c_CW-1:0] c_LAST = c_CW'(TICK_DIV - 1);

  logic [c_CW-1:0] r_cnt;
  logic            w_wrap;

  assign w_wrap = (r_cnt == c_LAST);

  // Divider counts 0..TICK_DIV-1 while enabled, holds otherwise; clr wins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
    end
  end

  assign tick = en && w_wrap && !clr;

endmodule : tick_gen
`default_nettype wire

// File: rtl/damage_gate.sv
`default_nettype none
// ============================================================================
//  Module      : damage_gate
//  Description : Turns per-source collision levels into single-cycle damage
//                pulses, enforces a post-hit invulnerability window with a
//                blink flag, and keeps a saturating hit tally.
//  Revision    : 1.0  initial release
// ============================================================================
module damage_gate
  import damage_gate_pkg::*;
#(
  parameter int NUM_SRC        = 4,
  parameter int TICK_DIV       = DEF_TICK_DIV,
  parameter int COOLDOWN_TICKS = DEF_COOLDOWN_TICKS,
  parameter int BLINK_TICKS    = 4,
  parameter int SRC_W          = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input wire           clk,
  input wire           rst,
  damage_gate_if.slave bus
);

  localparam int                     c_CD_W      = $clog2(COOLDOWN_TICKS + 1);
  localparam logic [c_CD_W-1:0]      c_CD_LOAD   = c_CD_W'(COOLDOWN_TICKS);
  localparam logic [c_CD_W-1:0]      c_CD_LAST   = c_CD_W'(1);
  localparam int                     c_BL_W      = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [c_BL_W-1:0]      c_BL_LAST   = c_BL_W'(BLINK_TICKS - 1);
  localparam logic [HIT_TOTAL_W-1:0] c_TOTAL_MAX = '1;

  gate_state_t            r_state;
  logic [c_CD_W-1:0]      r_cd_cnt;
  logic [c_BL_W-1:0]      r_bl_cnt;
  logic                   r_damage;
  logic                   r_invuln;
  logic                   r_blink;
  logic [SRC_W-1:0]       r_hit_src;
  logic [HIT_TOTAL_W-1:0] r_hit_total;

  logic w_tick;
  logic w_div_en;
  logic w_div_clr;

  // Lowest-index set source wins when several collide on the same cycle
  function automatic logic [SRC_W-1:0] f_lowest_src(input logic [NUM_SRC-1:0] v);
    logic [SRC_W-1:0] idx;
    idx = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      if (v[k]) idx = SRC_W'(k);
    end
    return idx;
  endfunction

  // Divider only runs during cooldown; held cleared in every other state so
  // each cooldown starts from a fresh count
  assign w_div_en  = bus.enable && (r_state == ST_COOLDOWN);
  assign w_div_clr = (r_state != ST_COOLDOWN);

  tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .en   (w_div_en),
    .clr  (w_div_clr),
    .tick (w_tick)
  );

  // Gate FSM with registered outputs; dead overrides everything else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_ARMED;
      r_cd_cnt    <= '0;
      r_bl_cnt    <= '0;
      r_damage    <= 1'b0;
      r_invuln    <= 1'b0;
      r_blink     <= 1'b0;
      r_hit_src   <= '0;
      r_hit_total <= '0;
    end else if (bus.dead) begin
      r_state  <= ST_HALT;
      r_damage <= 1'b0;
      r_invuln <= 1'b0;
      r_blink  <= 1'b0;
    end else begin
      r_damage <= 1'b0;
      case (r_state)
        ST_ARMED: begin
          if (bus.enable && (|bus.hit)) begin
            r_state   <= ST_STRIKE;
            r_damage  <= 1'b1;
            r_invuln  <= 1'b1;
            r_blink   <= 1'b1;
            r_hit_src <= f_lowest_src(bus.hit);
            if (r_hit_total != c_TOTAL_MAX) begin
              r_hit_total <= r_hit_total + 1'b1;
            end
          end
        end
        ST_STRIKE: begin
          // Strike lasts one cycle regardless of enable
          r_state  <= ST_COOLDOWN;
          r_cd_cnt <= c_CD_LOAD;
          r_bl_cnt <= '0;
        end
        ST_COOLDOWN: begin
          if (w_tick) begin
            if (r_cd_cnt == c_CD_LAST) begin
              r_state  <= ST_ARMED;
              r_invuln <= 1'b0;
              r_blink  <= 1'b0;
            end else begin
              r_cd_cnt <= r_cd_cnt - 1'b1;
              if (r_bl_cnt == c_BL_LAST) begin
                r_bl_cnt <= '0;
                r_blink  <= ~r_blink;
              end else begin
                r_bl_cnt <= r_bl_cnt + 1'b1;
              end
            end
          end
        end
        ST_HALT: begin
          // Terminal until reset; tally and source are kept for display
        end
        default: begin
          r_state <= ST_HALT;
        end
      endcase
    end
  end

  assign bus.damage    = r_damage;
  assign bus.invuln    = r_invuln;
  assign bus.blink     = r_blink;
  assign bus.hit_src   = r_hit_src;
  assign bus.hit_total = r_hit_total;

endmodule : damage_gate
`default_nettype wire

// File: tb/tb_damage_gate.sv
`default_nettype none
// ============================================================================
//  Module      : tb_damage_gate
//  Description : Self-checking bench for damage_gate against a time-based
//                reference model (elapsed enabled cycles of cooldown).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_damage_gate;
  import damage_gate_pkg::*;

  localparam int c_NSRC = 4;
  localparam int c_TD   = 4;
  localparam int c_CD   = 3;
  localparam int c_BL   = 1;
  localparam int c_SW   = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  damage_gate_if #(.NUM_SRC(c_NSRC), .SRC_W(c_SW)) gif ();

  damage_gate #(
    .NUM_SRC        (c_NSRC),
    .TICK_DIV       (c_TD),
    .COOLDOWN_TICKS (c_CD),
    .BLINK_TICKS    (c_BL),
    .SRC_W          (c_SW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (gif)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // m_cool = enabled cycles spent in cooldown so far, -1 when not cooling
  bit m_halt   = 1'b0;
  bit m_strike = 1'b0;
  int m_cool   = -1;
  int m_total  = 0;
  int m_src    = 0;

  function automatic int lowest_idx(input logic [c_NSRC-1:0] v);
    for (int i = 0; i < c_NSRC; i++) if (v[i]) return i;
    return 0;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_halt = 1'b0; m_strike = 1'b0; m_cool = -1; m_total = 0; m_src = 0;
    end else if (!m_halt) begin
      if (gif.dead) begin
        m_halt = 1'b1; m_strike = 1'b0; m_cool = -1;
      end else if (m_strike) begin
        m_strike = 1'b0; m_cool = 0;
      end else if (m_cool >= 0) begin
        if (gif.enable) m_cool++;
        if (m_cool == c_CD * c_TD) m_cool = -1;
      end else if (gif.enable && gif.hit != 0) begin
        m_strike = 1'b1;
        m_src    = lowest_idx(gif.hit);
        m_total  = (m_total < 255) ? m_total + 1 : 255;
      end
    end
  end

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    check_val("damage", gif.damage, m_strike);
    check_val("invuln", gif.invuln, (m_strike || m_cool >= 0));
    check_val("blink", gif.blink,
              (m_strike || (m_cool >= 0 && ((m_cool / (c_TD * c_BL)) % 2 == 0))));
    check_val("hit_src", gif.hit_src, m_src);
    check_val("hit_total", gif.hit_total, m_total);
  end

  // ---------------- observation counters ----------------
  int cyc = 0;
  int n_dmg = 0;
  int n_inv = 0;
  int last_dmg = -1;
  int gap = 0;

  always @(negedge clk) begin
    cyc++;
    if (gif.damage === 1'b1) begin
      if (last_dmg >= 0) gap = cyc - last_dmg;
      last_dmg = cyc;
      n_dmg++;
    end
    if (gif.invuln === 1'b1) n_inv++;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic clear_counts();
    n_dmg = 0; n_inv = 0; last_dmg = -1; gap = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_tot;
    gif.enable = 1'b1;
    gif.dead   = 1'b0;
    gif.hit    = '0;
    step(3);
    rst = 1'b0;

    // Reset state
    check_val("rst_invuln", gif.invuln, 0);
    check_val("rst_total", gif.hit_total, 0);
    check_val("rst_src", gif.hit_src, 0);

    // Single one-cycle hit on source 2
    step(5);
    clear_counts();
    gif.hit = 4'b0100;
    step(1);
    check_val("t1_pulse_now", gif.damage, 1);
    gif.hit = '0;
    step(30);
    check_val("t1_pulses", n_dmg, 1);
    check_val("t1_invuln_len", n_inv, 13);
    check_val("t1_src", gif.hit_src, 2);
    check_val("t1_total", gif.hit_total, 1);

    // Held contact re-strikes every 14 cycles
    clear_counts();
    gif.hit = 4'b0001;
    step(60);
    gif.hit = '0;
    check_val("t2_pulses", n_dmg, 5);
    check_val("t2_gap", gap, 14);
    step(20);

    // Simultaneous sources: one pulse, lowest index
    exp_tot = m_total + 1;
    clear_counts();
    gif.hit = 4'b1010;
    step(1);
    gif.hit = '0;
    step(20);
    check_val("t3_pulses", n_dmg, 1);
    check_val("t3_src", gif.hit_src, 1);
    check_val("t3_total", gif.hit_total, exp_tot);

    // Pause mid-cooldown stretches it to 32 cycles
    clear_counts();
    gif.hit = 4'b0010;
    step(1);
    gif.hit = '0;
    step(3);
    gif.enable = 1'b0;
    step(20);
    gif.enable = 1'b1;
    step(30);
    check_val("t5_invuln_len", n_inv, 33);
    check_val("t5_pulses", n_dmg, 1);

    // Hit while paused in ARMED: nothing
    clear_counts();
    gif.enable = 1'b0;
    gif.hit = 4'b1111;
    step(5);
    gif.hit = '0;
    gif.enable = 1'b1;
    step(2);
    check_val("t5_paused_pulses", n_dmg, 0);

    // dead and hit together in ARMED: halt without a pulse
    clear_counts();
    gif.dead = 1'b1;
    gif.hit = 4'b0001;
    step(1);
    gif.hit = '0;
    step(10);
    check_val("t5_dead_pulses", n_dmg, 0);
    check_val("t5_dead_invuln", n_inv, 0);
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    gif.dead = 1'b0;
    step(2);

    // dead during cooldown, then hammer hits
    gif.hit = 4'b0001;
    step(1);
    gif.hit = '0;
    step(5);
    exp_tot = m_total;
    clear_counts();
    gif.dead = 1'b1;
    step(1);
    gif.dead = 1'b0;
    repeat (100) begin
      gif.hit = 4'($urandom);
      step(1);
    end
    gif.hit = '0;
    check_val("t4_pulses", n_dmg, 0);
    check_val("t4_invuln", gif.invuln, 0);
    check_val("t4_blink", gif.blink, 0);
    check_val("t4_total_held", gif.hit_total, exp_tot);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check_val("t4_total_rst", gif.hit_total, 0);
    step(1);
    gif.hit = 4'b0100;
    step(1);
    gif.hit = '0;
    check_val("t4_rearmed", gif.damage, 1);
    step(20);

    // 260 isolated strikes saturate the tally
    repeat (260) begin
      gif.hit = 4'(1 << $urandom_range(0, 3));
      step(1);
      gif.hit = '0;
      step(14);
    end
    check_val("t6_saturate", gif.hit_total, 255);

    // Asynchronous reset mid-cooldown, away from any clock edge
    gif.hit = 4'b1000;
    step(1);
    gif.hit = '0;
    step(4);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_val("t6_async_invuln", gif.invuln, 0);
    check_val("t6_async_blink", gif.blink, 0);
    check_val("t6_async_damage", gif.damage, 0);
    check_val("t6_async_total", gif.hit_total, 0);
    check_val("t6_async_src", gif.hit_src, 0);
    step(2);
    rst = 1'b0;

    // Randomized traffic checked cycle by cycle against the model
    for (int i = 0; i < 2000; i++) begin
      gif.hit    = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      gif.enable = ($urandom_range(0, 7) != 0);
      gif.dead   = ($urandom_range(0, 299) == 0);
      if (m_halt && $urandom_range(0, 19) == 0) begin
        gif.dead = 1'b0;
        rst = 1'b1;
        step(1);
        rst = 1'b0;
      end else begin
        step(1);
      end
    end
    gif.hit = '0;
    gif.dead = 1'b0;
    step(2);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule : tb_damage_gate
`default_nettype wire
